// File: rtl/pipe_adder_pkg.sv
// Shared sizing helpers and defaults for the segmented pipelined adder.
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG   = 8;

    // Number of pipeline stages: one per SEG-bit segment.
    function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    // A build is legal only when WIDTH splits into whole, non-empty segments.
    function automatic bit seg_cfg_ok(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand and result handshakes of the pipelined adder.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipe_add_seg.sv
// SEG-bit combinational segment adder; also reports the carry into its MSB.
module pipe_add_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cm
);

    logic [SEG:0] full;

    // Segment sum; carry into the MSB recovered from the MSB sum bit.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
        s    = full[SEG-1:0];
        co   = full[SEG];
        cm   = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one register stage per SEG-bit carry segment.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic        clk,
    input  logic        reset,
    pipe_adder_if.slave ifc
);

    localparam int unsigned NSTG = calc_nstg(WIDTH, SEG);

    if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             adv;

    logic [SEG-1:0]   seg_a  [NSTG];
    logic [SEG-1:0]   seg_b  [NSTG];
    logic [SEG-1:0]   seg_s  [NSTG];
    logic             seg_cm [NSTG];
    logic [NSTG-1:0]  seg_ci;
    logic [NSTG-1:0]  seg_co;

    // acc: sum segments below the stage boundary, operand a above it.
    logic [WIDTH-1:0] acc_d [NSTG];
    logic [WIDTH-1:0] acc_q [NSTG];
    // bop: effective b, consumed one segment per stage.
    logic [WIDTH-1:0] bop_d [NSTG];
    logic [WIDTH-1:0] bop_q [NSTG];
    logic [NSTG-1:0]  cy_d, cy_q;
    logic [NSTG-1:0]  vld_d, vld_q;
    logic             ovf_d, ovf_q;

    // Subtract as a + ~b + 1.
    always_comb begin
        b_eff = ifc.sub ? ~ifc.b : ifc.b;
        c0    = ifc.sub ? 1'b1 : ifc.cin;
    end

    // Whole pipeline moves together unless the output beat is stalled.
    assign adv = !vld_q[NSTG-1] || ifc.out_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign seg_a[k]  = ifc.a[SEG-1:0];
            assign seg_b[k]  = b_eff[SEG-1:0];
            assign seg_ci[k] = c0;
        end else begin : g_body
            assign seg_a[k]  = acc_q[k-1][k*SEG +: SEG];
            assign seg_b[k]  = bop_q[k-1][k*SEG +: SEG];
            assign seg_ci[k] = cy_q[k-1];
        end

        pipe_add_seg #(.SEG(SEG)) u_seg (
            .a  (seg_a[k]),
            .b  (seg_b[k]),
            .ci (seg_ci[k]),
            .s  (seg_s[k]),
            .co (seg_co[k]),
            .cm (seg_cm[k])
        );
    end

    // Next stage contents: shift everything one stage and drop in each segment sum.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        acc_d = acc_q;
        bop_d = bop_q;
        if (adv) begin
            vld_d[0] = ifc.in_valid;
            acc_d[0] = ifc.a;
            bop_d[0] = b_eff;
            for (int unsigned k = 1; k < NSTG; k++) begin
                vld_d[k] = vld_q[k-1];
                acc_d[k] = acc_q[k-1];
                bop_d[k] = bop_q[k-1];
            end
            for (int unsigned k = 0; k < NSTG; k++) begin
                acc_d[k][k*SEG +: SEG] = seg_s[k];
                cy_d[k]                = seg_co[k];
            end
            ovf_d = seg_cm[NSTG-1] ^ seg_co[NSTG-1];
        end
    end

    // Datapath registers carry no reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        bop_q <= bop_d;
        cy_q  <= cy_d;
        ovf_q <= ovf_d;
    end

    // Stage valid bits; reset discards every in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign ifc.in_ready  = adv;
    assign ifc.out_valid = vld_q[NSTG-1];
    assign ifc.sum       = acc_q[NSTG-1];
    assign ifc.cout      = cy_q[NSTG-1];
    assign ifc.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: 4-stage (32/8) and 1-stage (8/8) builds side by side.
module tb_pipe_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned npass = 0;
    int unsigned ntot  = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    int          bp_mode [2];
    bit          stall_prev [2];
    logic [31:0] held_sum [2];
    logic        held_cout [2];
    logic        held_ovf [2];

    pipe_adder_if #(.WIDTH(32)) if32 ();
    pipe_adder_if #(.WIDTH(8))  if8 ();

    pipe_adder #(.WIDTH(32), .SEG(8)) u_dut32 (.clk(clk), .reset(reset), .ifc(if32.slave));
    pipe_adder #(.WIDTH(8),  .SEG(8)) u_dut8  (.clk(clk), .reset(reset), .ifc(if8.slave));

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        ntot++;
        if (act === req) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
    endfunction

    // Reference: integer arithmetic on unsigned and signed interpretations of w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint m, ua, ub, sa, sb, ru, rs;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            ru     = ua - ub;
            rs     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + longint'(cin);
            rs     = sa + sb + longint'(cin);
            e.cout = (ru >= m);
        end
        e.sum = 32'(ru & (m - 1));
        e.ovf = (rs >= m / 2) || (rs < -(m / 2));
        return e;
    endfunction

    task automatic mon_step(input int sel, input logic ov, input logic ordy, input logic ir,
                            input logic [31:0] s, input logic co, input logic of);
        exp_t  e;
        string tag;
        int    qn;
        tag = (sel == 0) ? "w32" : "w8";
        qn  = (sel == 0) ? q32.size() : q8.size();
        chk({tag, "_in_ready"}, 64'(ir), 64'(!ov || ordy));
        if (stall_prev[sel]) begin
            chk({tag, "_hold_valid"}, 64'(ov), 64'(1'b1));
            chk({tag, "_hold_sum"}, 64'(s), 64'(held_sum[sel]));
            chk({tag, "_hold_cout"}, 64'(co), 64'(held_cout[sel]));
            chk({tag, "_hold_ovf"}, 64'(of), 64'(held_ovf[sel]));
        end
        if (ov && ordy) begin
            if (qn == 0) begin
                chk({tag, "_unexpected_beat"}, 64'(ov), 64'(1'b0));
            end else begin
                if (sel == 0) e = q32.pop_front();
                else          e = q8.pop_front();
                chk({tag, "_sum"}, 64'(s), 64'(e.sum));
                chk({tag, "_cout"}, 64'(co), 64'(e.cout));
                chk({tag, "_ovf"}, 64'(of), 64'(e.ovf));
            end
        end
        stall_prev[sel] = ov && !ordy;
        held_sum[sel]   = s;
        held_cout[sel]  = co;
        held_ovf[sel]   = of;
    endtask

    // Monitor: compares every accepted output beat against the scoreboard.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            stall_prev[0] = 1'b0;
            stall_prev[1] = 1'b0;
        end else begin
            mon_step(0, if32.out_valid, if32.out_ready, if32.in_ready, if32.sum, if32.cout, if32.ovf);
            mon_step(1, if8.out_valid, if8.out_ready, if8.in_ready, 32'(if8.sum), if8.cout, if8.ovf);
        end
    end

    // Consumer: always ready, random backpressure, or stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if32.out_ready = (bp_mode[0] == 1) ? 1'($urandom_range(0, 1)) : (bp_mode[0] == 0);
            if8.out_ready  = (bp_mode[1] == 1) ? 1'($urandom_range(0, 1)) : (bp_mode[1] == 0);
        end
    end

    task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        if (sel == 0) begin
            if32.in_valid = v; if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub;
        end else begin
            if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub;
        end
    endtask

    // Offer one beat until taken; expectation is queued on the accepting cycle.
    task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
        exp_t e;
        bit   acc;
        logic ir;
        e   = model((sel == 0) ? 32 : 8, a, b, cin, sub);
        acc = 1'b0;
        drive(sel, 1'b1, a, b, cin, sub);
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            ir = (sel == 0) ? if32.in_ready : if8.in_ready;
            if (ir) begin
                acc = 1'b1;
                if (sel == 0) q32.push_back(e);
                else          q8.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 64'(acc), 64'(1'b1));
        if (sel == 0) if32.in_valid = 1'b0;
        else          if8.in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe; latency in cycles must equal the stage count.
    task automatic directed(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        int n;
        bit seen;
        send(sel, a, b, cin, sub);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (sel == 0) ? if32.out_valid : if8.out_valid;
        end
        chk((sel == 0) ? "w32_latency" : "w8_latency", 64'(n), (sel == 0) ? 64'(4) : 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int sel);
        int qn;
        qn = (sel == 0) ? q32.size() : q8.size();
        for (int i = 0; i < 400 && qn != 0; i++) begin
            @(negedge clk);
            qn = (sel == 0) ? q32.size() : q8.size();
        end
        chk((sel == 0) ? "w32_drain" : "w8_drain", 64'(qn), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        bp_mode = '{0, 0};
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        if32.out_ready = 1'b1;
        if8.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("w32_rst_out_valid", 64'(if32.out_valid), 64'(1'b0));
        chk("w32_rst_in_ready", 64'(if32.in_ready), 64'(1'b1));
        chk("w8_rst_out_valid", 64'(if8.out_valid), 64'(1'b0));
        chk("w8_rst_in_ready", 64'(if8.in_ready), 64'(1'b1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("w32_idle", 64'(if32.out_valid), 64'(1'b0));
            chk("w8_idle", 64'(if8.out_valid), 64'(1'b0));
        end
        @(posedge clk);
        #1;

        directed(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        directed(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        directed(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        directed(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        directed(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        directed(1, 32'h80, 32'h80, 1'b0, 1'b0);
        directed(1, 32'h7F, 32'h01, 1'b0, 1'b0);
        directed(1, 32'h00, 32'h01, 1'b1, 1'b1);

        bp_mode[0] = 1;
        for (int i = 0; i < 20; i++) begin
            send(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain(0);
        bp_mode[0] = 0;

        bp_mode[1] = 1;
        for (int i = 0; i < 20; i++) begin
            send(1, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain(1);
        bp_mode[1] = 0;

        // Three beats in flight, oldest stalled at the output, then reset.
        bp_mode[0]     = 2;
        if32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("w32_prerst_valid", 64'(if32.out_valid), 64'(1'b1));
        reset = 1'b1;
        q32.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("w32_midrst_out_valid", 64'(if32.out_valid), 64'(1'b0));
        bp_mode[0]     = 0;
        if32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w32_no_stale", 64'(if32.out_valid), 64'(1'b0));
        end

        chk("w32_q_empty", 64'(q32.size()), 64'(0));
        chk("w8_q_empty", 64'(q8.size()), 64'(0));
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", npass, ntot);
        $fatal(1, "watchdog expired");
    end

endmodule
